// File: rtl/riscv_pkg.sv
// Shared definitions for the program-memory boot loader and its byte packer.
package riscv_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned PMEM_DEPTH     = 32;
  localparam int unsigned LANE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/progmem_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into one word and flags the
// handshake that completes it.
module byte_packer
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              hs_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  logic [BYTES_PER_WORD-1:0][7:0] lane_q, lane_d;
  logic [LANE_IDX_W-1:0]          idx_q, idx_d;

  always_comb begin
    lane_d = lane_q;
    idx_d  = idx_q;
    if (clr_i) begin
      lane_d = '0;
      idx_d  = '0;
    end else if (hs_i) begin
      lane_d[idx_q] = byte_i;
      idx_d         = idx_q + LANE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      idx_q  <= '0;
    end else begin
      lane_q <= lane_d;
      idx_q  <= idx_d;
    end
  end

  // The completed word sits in lane_q for the cycle after its last byte,
  // which is exactly the cycle the memory write is issued.
  assign word_o      = lane_q;
  assign word_done_o = hs_i && (idx_q == LANE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/progmem_loader.sv
// Boot loader: streams bytes into program memory word by word, then hands the
// memory port to the core fetch stage and releases the core.
module progmem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH  = PMEM_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              core_run,
  input  logic              core_rd_en,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [WORD_W-1:0] core_rdata,
  output logic              core_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   words_left_q, words_left_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;

  logic              start_ok;
  logic              load_begin;
  logic              hs;
  logic              pk_done;
  logic [WORD_W-1:0] pk_word;

  assign start_ok   = start && (word_count != '0) && (word_count <= DEPTH_CNT);
  assign load_begin = start_ok && ((state_q == IDLE) || (state_q == RUN));
  assign hs         = s_valid && s_ready;

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (load_begin),
    .hs_i        (hs),
    .byte_i      (s_data),
    .word_o      (pk_word),
    .word_done_o (pk_done)
  );

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    word_addr_d  = word_addr_q;
    wr_d         = 1'b0;
    err_d        = 1'b0;

    // Counters advance at the end of each write cycle; a new start below
    // overrides them, and a write is never pending in IDLE or RUN.
    if (wr_q) begin
      word_addr_d  = word_addr_q + ADDR_W'(1);
      words_left_d = words_left_q - (ADDR_W + 1)'(1);
    end

    unique case (state_q)
      IDLE, RUN: begin
        if (start) begin
          if (start_ok) begin
            state_d      = LOAD;
            words_left_d = word_count;
            word_addr_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pk_done) begin
          wr_d = 1'b1;
          if (words_left_q == (ADDR_W + 1)'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      word_addr_q  <= '0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      word_addr_q  <= word_addr_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_q) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = word_addr_q;
      mem_wdata = pk_word;
    end else if (state_q == RUN) begin
      mem_en   = core_rd_en;
      mem_addr = core_addr;
    end
  end

  assign s_ready    = (state_q == LOAD);
  assign core_run   = (state_q == RUN);
  assign core_gnt   = (state_q == RUN);
  assign busy       = (state_q == LOAD) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign core_rdata = mem_rdata;

endmodule

// File: doc/progmem_loader.md
# progmem_loader

Boot-time controller that owns the processor's program-memory port. Out of reset it holds the core stopped, accepts a byte stream, packs bytes little-endian into 32-bit words, and writes them to consecutive program-memory addresses from word 0. It then hands the memory port to the core's fetch stage and releases the core. It is the synthesizable replacement for file-based program preload, and sits between the byte source, the program memory, and the core's fetch/run control.

## Interface
- DEPTH, 32: program memory depth in words.
- ADDR_W, 5: word-address width, equal to log2(DEPTH).

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load.
- word_count  in  ADDR_W+1  number of words to load; sampled with start.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts a byte this cycle.
- core_run  out  1  core may execute; while low the core stays in reset.
- core_rd_en  in  1  core fetch enable.
- core_addr  in  ADDR_W  core fetch word address.
- core_rdata  out  32  fetch data; combinational copy of mem_rdata.
- core_gnt  out  1  high while the core owns the memory port.
- mem_en  out  1  program memory enable.
- mem_we  out  1  program memory write enable.
- mem_addr  out  ADDR_W  program memory word address.
- mem_wdata  out  32  program memory write data.
- mem_rdata  in  32  program memory read data; synchronous, 1-cycle latency.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- States are IDLE, LOAD, DONE and RUN. Reset enters IDLE.
- **IDLE**
  - s_ready=0, core_run=0, core_gnt=0. Memory port is idle: mem_en=0, mem_we=0.
  - start with 1 ≤ word_count ≤ DEPTH: latch the count, clear byte_idx and word_addr, go to LOAD.
  - start with word_count=0 or word_count>DEPTH: err=1 for the next cycle; stay in IDLE.
- **LOAD**
  - s_ready=1, except in the cycle after the final byte has been accepted.
  - Each handshake (s_valid & s_ready) writes s_data into lane byte_idx (byte 0 → bits [7:0]) and increments byte_idx mod 4.
  - On the handshake of lane 3, the next cycle drives mem_en=1, mem_we=1, mem_addr=word_addr and mem_wdata=the packed word. word_addr then increments and words_left decrements.
  - When the final lane-3 byte is accepted, the state goes to DONE.
  - start is ignored in LOAD.
- **DONE**
  - Lasts one cycle and carries the final word write. done=1, s_ready=0.
  - Next state is RUN.
- **RUN**
  - core_run=1, core_gnt=1, s_ready=0.
  - Memory port follows the core: mem_en=core_rd_en, mem_addr=core_addr, mem_we=0, mem_wdata=0.
  - A valid start drops core_run and core_gnt on the next cycle and enters LOAD (reload).
  - An invalid start in RUN pulses err; the state stays RUN.
- Outside RUN, core_rdata still mirrors mem_rdata, and core fetches have no effect on the memory.
- Bytes not handshaken are never consumed. No byte is accepted outside LOAD.

## Timing
- Reset values of all outputs are 0. The held state is state=IDLE, byte_idx=0, word_addr=0, words_left=0.
- start registered at edge 0 → LOAD from cycle 1.
- For N words with back-to-back bytes:
  - bytes are accepted in cycles 1..4N;
  - word k is written in cycle 4k+5 (k from 0);
  - the final write and done both occur in cycle 4N+1;
  - core_run=1 from cycle 4N+2.
- Gaps in s_valid stall the load with no timeout; byte_idx and the partial word are held.
- Reset in mid-load: the partial word is discarded, outputs return to reset values the next cycle, and core_run stays 0. Words already written remain in memory.
- start arriving in the same cycle as the DONE→RUN transition is treated as a RUN-state start in the following cycle only if it is still asserted then; a single-cycle start in DONE is dropped.
- word_addr wraps only at DEPTH, which cannot be reached because word_count ≤ DEPTH.

## Structure
- Shared package `riscv_pkg` holds:
  - the loader state enum (IDLE, LOAD, DONE, RUN);
  - constants WORD_W=32, BYTES_PER_WORD=4, PMEM_DEPTH=32.
- Sub-module `byte_packer` holds the lane register, byte_idx and the word-complete strobe.
- FSM, counters and port mux stay in progmem_loader.

## Test plan
- **Reset defaults.** rst for 3 cycles → every output is 0 and the state is IDLE, even with s_valid=1.
- **Two-word load.** start, word_count=2, bytes 0x13,0x05,0x50,0x00,0xB3,0x05,0xA5,0x00 back-to-back →
  - mem writes addr0=0x00500513 in cycle 5 and addr1=0x00A505B3 in cycle 9;
  - done in cycle 9;
  - core_run=1 in cycle 10.
- **Handshake stall.** s_valid toggled 1,0,0,1,... during a 1-word load → the byte order is kept and the single write occurs 1 cycle after the 4th accepted byte.
- **Rejected starts.** start with word_count=0, and separately word_count=33 → err pulses one cycle, state stays IDLE, and no memory write occurs.
- **Core fetch and reload.**
  - In RUN, core_rd_en=1, core_addr=1 → mem_addr=1, and core_rdata=0x00A505B3 one cycle later.
  - A valid start in RUN → core_run=0 the next cycle, and the state is LOAD.
- **Reset in mid-load.** rst after 6 of 8 bytes → no write to addr1, core_run stays 0, and a new load then starts cleanly at addr0.
